icache_axi_refill: RTL and testbench
====================================

# icache_axi_refill

Read-only AXI master that serves the instruction cache's line-refill port. Accepts one line-refill request at a time from the I-cache miss path and issues a single AXI burst of `LINE_WORD` 32-bit beats. Collects the beats into a line buffer and returns the whole line to the cache in one cycle. Sits between the I-cache (which acts as the refill master) and the AXI crossbar / arbiter.

## Interface
Parameters:
- `LINE_WORD`, default 4: words per I-cache line. Allowed values are 2, 4, 8, 16.
- `AXI_ID`, default 4'd0: constant value driven on `arid`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rd_req` in 1: refill request from the cache.
- `rd_addr` in 32: miss address; the byte offset within the word is ignored.
- `rd_rdy` out 1: block idle; a request is accepted this cycle.
- `ret_valid` out 1: line returned; one-cycle pulse.
- `ret_data` out LINE_WORD*32: refilled line, word 0 in bits [31:0].
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3, `arvalid` out 1: AXI read-address channel.
- `arready` in 1: AXI read-address channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1: AXI read-data channel.
- `rready` out 1: AXI read-data channel.

## Operation
- FSM states:
  - IDLE: `rd_rdy`=1. On `rd_req`, latch the address and go to AR.
  - AR: `arvalid`=1. On `arready`, go to R.
  - R: `rready`=1. Each `rvalid&rready` writes `rdata` into the line buffer and increments the beat counter. The handshake with beat counter == LINE_WORD-1 goes to DONE.
  - DONE: `ret_valid`=1, then return to IDLE.
- Constant AR fields:
  - `arlen` = LINE_WORD-1
  - `arsize` = 3'b010
  - `arlock` = 0
  - `arcache` = 0
  - `arprot` = 0
  - `arid` = `AXI_ID`
- AR fields are stable while `arvalid` is high and do not change until `arready`.
- The beat counter has width clog2(LINE_WORD) and is authoritative for completion.
  - `rlast` does not end the burst.
  - A beat with `rlast` before the final count is stored, and the block keeps waiting.
- `rresp` and `rid` are not checked; data is stored regardless.
- Buffer slot written by beat k: (start_word + k) mod LINE_WORD. start_word is set by the configuration option below. `ret_data` is therefore always in line order.
- `ret_data` holds its value after DONE until the next refill's first beat overwrites a word. The cache must capture the line on `ret_valid`.
- `rd_req` while not in IDLE is ignored; the cache must hold its request until `rd_rdy`.

## Timing
- Reset values:
  - state IDLE
  - `rd_rdy`=1, `ret_valid`=0
  - `arvalid`=0, `rready`=0
  - `ret_data`=0
  - beat counter 0
- Reset is asynchronous. When asserted mid-burst, the block drops `arvalid`/`rready` immediately and abandons the burst. The system-wide reset covers the AXI slave, so no drain is performed.
- `rd_req` accepted at cycle 0 gives `arvalid`=1 from cycle 1; `araddr` is registered.
- Best case: `arready` at cycle 1 and beats at cycles 2..LINE_WORD+1. `ret_valid` is then at cycle LINE_WORD+2 and `rd_rdy`=1 at cycle LINE_WORD+3. With LINE_WORD=4: 6 cycles from request to line.
- `rvalid` gaps stall the counter with no side effect.
- `rvalid` while in AR (before `arready`) is not accepted, because `rready`=0 there.
- Throughput is one refill in flight; there is no request queue.

## Configuration
- `ICACHE_REFILL_CWF_EN` (critical-word-first) defined:
  - `arburst`=2'b10 (WRAP).
  - `araddr` = {rd_addr[31:2], 2'b00}.
  - start_word = rd_addr word index within the line.
  - This requires LINE_WORD to be 2, 4, 8 or 16 (legal AXI wrap lengths).
- Not defined:
  - `arburst`=2'b01 (INCR).
  - `araddr` is the line-aligned rd_addr.
  - start_word = 0.
- Cycle timing is identical in both builds.

## Test plan
- Reset then idle: after reset, `rd_rdy`=1, `arvalid`=0, `ret_valid`=0, `ret_data`=0.
- INCR build, LINE_WORD=4, `rd_req` with `rd_addr`=0x1FC0_0018, slave always ready, beats 0xA0..0xA3:
  - `araddr`=0x1FC0_0010, `arlen`=3.
  - `ret_valid` 6 cycles after the request.
  - `ret_data`={A3,A2,A1,A0}.
- CWF build, same request:
  - `araddr`=0x1FC0_0018, `arburst`=WRAP.
  - Beats A2,A3,A0,A1 give `ret_data`={A3,A2,A1,A0}.
- `arready` delayed 5 cycles and `rvalid` toggling every other cycle:
  - AR fields stay stable throughout.
  - Exactly 4 beats are stored.
  - `ret_valid` is one cycle wide.
- Early `rlast` on beat 2 of 4: the block stays in R and completes only after the 4th beat.
- `rst` asserted after beat 1 of 4:
  - `rready`/`arvalid` drop in the same cycle and the state is IDLE.
  - A new request afterwards completes correctly with no stale `ret_valid`.

Source files
------------

// File: rtl/icache_axi_refill.sv
// rtl/icache_axi_refill.sv - read-only AXI burst master for I-cache line refill.
// Optional critical-word-first WRAP bursts when ICACHE_REFILL_CWF_EN is defined.
module icache_axi_refill #(
  parameter int         LINE_WORD = 4,
  parameter logic [3:0] AXI_ID    = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [31:0]             rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic [LINE_WORD*32-1:0] ret_data,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int CW  = (LINE_WORD > 1) ? $clog2(LINE_WORD) : 1;
  localparam int OFF = CW + 2;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   start_word;
  logic [CW-1:0]   wr_slot;
  logic [31:0]     addr_q;
  logic [31:0]     line_buf [LINE_WORD];
  logic            beat_hs;
  logic            unused_inputs;

  assign beat_hs = rvalid & rready;
  // Slot index wraps naturally because LINE_WORD is a power of two.
  assign wr_slot = start_word + beat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    case (state)
      S_IDLE: begin
        rd_rdy = 1'b1;
        if (rd_req) state_nxt = S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        // Completion follows the beat count only; rlast is deliberately ignored.
        if (beat_hs && beat_cnt == CW'(LINE_WORD - 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        ret_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      start_word <= '0;
      beat_cnt   <= '0;
      for (int i = 0; i < LINE_WORD; i++) line_buf[i] <= '0;
    end else begin
      if (state == S_IDLE && rd_req) begin
        beat_cnt <= '0;
`ifdef ICACHE_REFILL_CWF_EN
        addr_q     <= {rd_addr[31:2], 2'b00};
        start_word <= rd_addr[OFF-1:2];
`else
        addr_q     <= {rd_addr[31:OFF], {OFF{1'b0}}};
        start_word <= '0;
`endif
      end
      if (beat_hs) begin
        line_buf[wr_slot] <= rdata;
        beat_cnt          <= beat_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LINE_WORD; g++) begin : g_ret
    assign ret_data[g*32 +: 32] = line_buf[g];
  end

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'(LINE_WORD - 1);
  assign arsize  = 3'b010;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
`ifdef ICACHE_REFILL_CWF_EN
  assign arburst       = 2'b10;
  assign unused_inputs = ^{rid, rresp, rlast, rd_addr[1:0]};
`else
  assign arburst       = 2'b01;
  assign unused_inputs = ^{rid, rresp, rlast, rd_addr[OFF-1:0]};
`endif

endmodule

// File: tb/tb_icache_axi_refill.sv
// tb/tb_icache_axi_refill.sv - self-checking bench for icache_axi_refill (LINE_WORD=4).
module tb_icache_axi_refill;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req;
  logic [31:0]   rd_addr;
  logic          rd_rdy, ret_valid;
  logic [127:0]  ret_data;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst, arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid, arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  icache_axi_refill #(.LINE_WORD(LW), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          ar_delay;
    int          mode;        // 0 rvalid always, 1 every other cycle, 2 random
    int          rlast_beat;  // beat index carrying an early rlast, -1 for none
    logic [31:0] base;
  } vec_t;

  task automatic idle_inputs();
    rd_req = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rdata = 32'h0; rid = 4'h0; rresp = 2'b00;
  endtask

  // Slave plus reference: line word i holds base+i; the slave sends words in the
  // order implied by the burst type and the bench predicts latency from the
  // offered rvalid pattern alone.
  task automatic run_refill(input vec_t v, input string tag);
    logic [31:0]  words [LW];
    logic         offer [64];
    logic [127:0] exp_line, got_line;
    logic [31:0]  exp_araddr;
    logic [1:0]   exp_burst;
    int start, a_cyc, exp_lat, n, cyc, beat, lat, width, ar_bad, ar_cycles, rdy_after;
    for (int i = 0; i < LW; i++) begin
      words[i] = v.base + 32'(i);
      exp_line[i*32 +: 32] = words[i];
    end
`ifdef ICACHE_REFILL_CWF_EN
    start = int'((v.addr >> 2) % LW);
    exp_araddr = v.addr & ~32'h3;
    exp_burst = 2'b10;
`else
    start = 0;
    exp_araddr = v.addr & ~32'hF;
    exp_burst = 2'b01;
`endif
    a_cyc = 1 + v.ar_delay;
    for (int c = 0; c < 64; c++) begin
      case (v.mode)
        0:       offer[c] = 1'b1;
        1:       offer[c] = ((c % 2) == ((a_cyc + 1) % 2));
        default: offer[c] = (c > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
    end
    exp_lat = -1;
    n = 0;
    for (int c = a_cyc + 1; c < 64; c++) begin
      if (offer[c]) begin
        n++;
        if (n == LW) begin exp_lat = c + 1; break; end
      end
    end

    rd_addr = v.addr; rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0; rd_addr = $urandom;
    cyc = 1; beat = 0; lat = 0; width = 0; ar_bad = 0; ar_cycles = 0; rdy_after = -1;
    got_line = '0;
    while (cyc < 80) begin
      if (arvalid) begin
        ar_cycles++;
        if (araddr !== exp_araddr || arlen !== 8'd3 || arsize !== 3'b010 ||
            arburst !== exp_burst || arlock !== 2'b00 || arcache !== 4'h0 ||
            arprot !== 3'b000 || arid !== 4'h0) ar_bad++;
      end
      if (ret_valid) begin
        if (width == 0) begin lat = cyc; got_line = ret_data; end
        width++;
      end else if (width > 0) begin
        rdy_after = int'(rd_rdy);
        break;
      end
      arready = (cyc >= a_cyc);
      rid = 4'($urandom); rresp = 2'($urandom);
      if (cyc <= a_cyc) begin
        // Junk beat presented before the address handshake must not be taken.
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rlast = 1'b0;
      end else begin
        rvalid = offer[cyc] && (beat < LW);
        rdata  = rvalid ? words[(start + beat) % LW] : 32'hDEADBEEF;
        rlast  = (beat == LW - 1) || (beat == v.rlast_beat);
        if (rvalid && rready) beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    check({tag, ".latency"}, 128'(lat), 128'(exp_lat));
    check({tag, ".ret_valid_width"}, 128'(width), 128'(1));
    check({tag, ".ret_data"}, got_line, exp_line);
    check({tag, ".ar_fields_bad_cycles"}, 128'(ar_bad), 128'(0));
    check({tag, ".arvalid_cycles"}, 128'(ar_cycles), 128'(a_cyc));
    check({tag, ".beats"}, 128'(beat), 128'(LW));
    check({tag, ".rd_rdy_after"}, 128'(rdy_after), 128'(1));
  endtask

  vec_t vecs [5];
  vec_t rv;
  int   stale;

  initial begin
    vecs[0] = '{addr: 32'h1FC0_0018, ar_delay: 0, mode: 0, rlast_beat: -1, base: 32'hA0};
    vecs[1] = '{addr: 32'h1FC0_0018, ar_delay: 5, mode: 1, rlast_beat: -1, base: 32'hB0};
    vecs[2] = '{addr: 32'h0000_1004, ar_delay: 0, mode: 0, rlast_beat: 1,  base: 32'hC0};
    vecs[3] = '{addr: 32'h0000_000C, ar_delay: 2, mode: 2, rlast_beat: -1, base: 32'hD0};
    vecs[4] = '{addr: 32'hFFFF_FFF3, ar_delay: 1, mode: 1, rlast_beat: 0,  base: 32'hE0};

    idle_inputs();
    rd_addr = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.rd_rdy", 128'(rd_rdy), 128'(1));
    check("reset.arvalid", 128'(arvalid), 128'(0));
    check("reset.rready", 128'(rready), 128'(0));
    check("reset.ret_valid", 128'(ret_valid), 128'(0));
    check("reset.ret_data", ret_data, 128'(0));

    for (int i = 0; i < 5; i++) run_refill(vecs[i], $sformatf("vec%0d", i));

    // Reset after the second beat: outputs drop asynchronously, no stale line.
    rd_addr = 32'h2000_0040; rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0; arready = 1'b1;
    @(posedge clk); #1 arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
    @(posedge clk); #1 rdata = 32'h2222_2222;
    @(posedge clk); #1 rvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midreset.rready", 128'(rready), 128'(0));
    check("midreset.arvalid", 128'(arvalid), 128'(0));
    check("midreset.rd_rdy", 128'(rd_rdy), 128'(1));
    check("midreset.ret_data", ret_data, 128'(0));
    #2 rst = 1'b0;
    stale = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ret_valid) stale++;
    end
    check("midreset.stale_ret_valid", 128'(stale), 128'(0));
    run_refill(vecs[0], "after_reset");

    for (int i = 0; i < 20; i++) begin
      rv.addr       = $urandom;
      rv.ar_delay   = int'($urandom_range(0, 4));
      rv.mode       = int'($urandom_range(0, 2));
      rv.rlast_beat = int'($urandom_range(0, 4)) - 1;
      rv.base       = $urandom;
      run_refill(rv, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
